// File: rtl/instr_line_buffer_pkg.sv
// Shared constants, FSM encoding and line word extraction for instr_line_buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package instr_line_buffer_pkg;

    localparam int LINE_BYTES     = 16;
    localparam int WORDS_PER_LINE = 4;
    localparam int OFFSET_BITS    = 4;

    typedef enum logic {
        ILB_IDLE,
        ILB_FILL
    } ilb_state_e;

    function automatic logic [31:0] line_word(input logic [127:0] line, input logic [1:0] sel);
        return line[{sel, 5'd0} +: 32];
    endfunction

endpackage

// File: rtl/sat_counter32.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
// Latency: count visible one cycle after inc_i.
// Backpressure: none; every inc_i pulse is counted until saturation.
module sat_counter32 (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        inc_i,
    output logic [31:0] cnt_o
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_o <= '0;
        end else if (inc_i && (cnt_o != 32'hFFFF_FFFF)) begin
            cnt_o <= cnt_o + 32'd1;
        end
    end

endmodule

// File: rtl/instr_line_buffer.sv
// Single 16-byte line buffer serving 32-bit fetches, refilling from RAM port A on a miss.
// Latency: hit 1 cycle (gnt t, rvalid t+1); miss 2 cycles (gnt t, rvalid t+2).
// Backpressure: gnt held low during FILL; rvalid is a 1-cycle pulse the core must take.
module instr_line_buffer
    import instr_line_buffer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 22
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  instr_req_i,
    input  logic [31:0]           instr_addr_i,
    output logic                  instr_gnt_o,
    output logic                  instr_rvalid_o,
    output logic [31:0]           instr_rdata_o,
    input  logic                  flush_i,
    output logic                  ram_en_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    input  logic [127:0]          ram_rdata_i,
    output logic [31:0]           hit_cnt_o,
    output logic [31:0]           miss_cnt_o
);

    localparam int TAG_WIDTH = ADDR_WIDTH - OFFSET_BITS;

    ilb_state_e           state_q;
    logic                 valid_q;
    logic [127:0]         line_q;
    logic [TAG_WIDTH-1:0] tag_q;
    logic [1:0]           word_sel_q;

    logic [TAG_WIDTH-1:0] req_tag;
    logic                 hit;
    logic                 in_idle;
    logic                 hit_inc;
    logic                 miss_inc;
    logic                 unused_addr_bits;

    // Bits above ADDR_WIDTH and the byte offset never select anything.
    assign unused_addr_bits = ^instr_addr_i;

    assign req_tag  = instr_addr_i[ADDR_WIDTH-1:OFFSET_BITS];
    assign in_idle  = (state_q == ILB_IDLE);
    assign hit      = valid_q && !flush_i && (tag_q == req_tag);
    assign hit_inc  = in_idle && instr_req_i && hit;
    assign miss_inc = in_idle && instr_req_i && !hit;

    assign instr_gnt_o = in_idle && instr_req_i;
    assign ram_en_o    = miss_inc;
    assign ram_addr_o  = ram_en_o ? {req_tag, {OFFSET_BITS{1'b0}}} : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= ILB_IDLE;
            valid_q        <= 1'b0;
            line_q         <= '0;
            tag_q          <= '0;
            word_sel_q     <= '0;
            instr_rvalid_o <= 1'b0;
            instr_rdata_o  <= '0;
        end else begin
            instr_rvalid_o <= 1'b0;
            case (state_q)
                ILB_IDLE: begin
                    if (flush_i) begin
                        valid_q <= 1'b0;
                    end
                    if (instr_req_i) begin
                        if (hit) begin
                            instr_rvalid_o <= 1'b1;
                            instr_rdata_o  <= line_word(line_q, instr_addr_i[3:2]);
                        end else begin
                            // Line is invalid until the fill lands, so a stale tag never hits.
                            tag_q      <= req_tag;
                            word_sel_q <= instr_addr_i[3:2];
                            valid_q    <= 1'b0;
                            state_q    <= ILB_FILL;
                        end
                    end
                end
                ILB_FILL: begin
                    line_q         <= ram_rdata_i;
                    valid_q        <= !flush_i;
                    instr_rvalid_o <= 1'b1;
                    instr_rdata_o  <= line_word(ram_rdata_i, word_sel_q);
                    state_q        <= ILB_IDLE;
                end
                default: begin
                    state_q <= ILB_IDLE;
                end
            endcase
        end
    end

    sat_counter32 u_hit_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (hit_inc),
        .cnt_o  (hit_cnt_o)
    );

    sat_counter32 u_miss_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (miss_inc),
        .cnt_o  (miss_cnt_o)
    );

endmodule

// File: doc/instr_line_buffer.md
# instr_line_buffer

Single-line instruction fetch buffer between the core's instruction fetch interface and the 128-bit read port (port A) of the verilator-model dual-port RAM. It holds the last 16-byte line fetched and serves 32-bit instruction words from it. A RAM read is issued only when the requested word falls outside the buffered line. Hit and miss counts are exported for simulation performance reporting.

## Interface
- `ADDR_WIDTH`, default 22: RAM byte-address width; must match the RAM's `ADDR_WIDTH`; minimum 5.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `instr_req_i`  in  1  fetch request.
- `instr_addr_i`  in  32  fetch byte address; bits [1:0] ignored.
- `instr_gnt_o`  out  1  request accepted this cycle (combinational).
- `instr_rvalid_o`  out  1  `instr_rdata_o` valid this cycle (registered).
- `instr_rdata_o`  out  32  fetched instruction word (registered).
- `flush_i`  in  1  invalidate the buffered line (fence.i).
- `ram_en_o`  out  1  RAM port-A read enable (combinational).
- `ram_addr_o`  out  ADDR_WIDTH  RAM port-A byte address, 16-byte aligned.
- `ram_rdata_i`  in  128  RAM port-A data, valid one cycle after `ram_en_o`; byte k of the line is in bits [8k+7:8k].
- `hit_cnt_o`  out  32  accepted requests served from the buffer.
- `miss_cnt_o`  out  32  accepted requests that caused a RAM read.

## Operation
- State: line register (128 bits), tag (`addr[ADDR_WIDTH-1:4]`), valid bit, FSM {IDLE, FILL}, response registers.
- **Hit** is `valid && !flush_i && tag == instr_addr_i[ADDR_WIDTH-1:4]`. Address bits at and above `ADDR_WIDTH` are ignored.
- **IDLE:**
  - `instr_gnt_o = instr_req_i`.
  - On a hit: the next cycle has `instr_rvalid_o=1` and `instr_rdata_o` = line word `instr_addr_i[3:2]`; `hit_cnt` increments; the FSM stays in IDLE.
  - On a miss: `ram_en_o=1` and `ram_addr_o={instr_addr_i[ADDR_WIDTH-1:4],4'b0}` in the same cycle; the word select `addr[3:2]` and the tag are latched; `miss_cnt` increments; the FSM goes to FILL.
- **FILL:**
  - `instr_gnt_o=0` and `ram_en_o=0`.
  - At the clock edge: `ram_rdata_i` is written into the line register, the tag is written, `valid` is set, `instr_rvalid_o`/`instr_rdata_o` are loaded from the latched word select, and the FSM returns to IDLE.
- **Flush:**
  - `flush_i` in IDLE clears `valid` at the edge. A request in the same cycle is treated as a miss, and the line it fetches is valid afterwards.
  - `flush_i` in FILL: the fill completes and its data is delivered, but `valid` ends up 0.
- Only one transaction is outstanding at a time. `instr_rvalid_o` is a 1-cycle pulse and has no back-pressure; the core always accepts it.
- Counters saturate at 0xFFFF_FFFF and are cleared only by reset.
- `ram_addr_o` is 0 when `ram_en_o=0`.

## Timing
- Reset values (asynchronous, while `rst_ni=0`): state=IDLE, valid=0, line=0, tag=0, `instr_rvalid_o=0`, `instr_rdata_o=0`, `hit_cnt_o=0`, `miss_cnt_o=0`. The combinational outputs `instr_gnt_o`/`ram_en_o` are 0 unless a request is present in IDLE.
- Hit: gnt at cycle t, rvalid at t+1. Back-to-back hits give one gnt and one rvalid per cycle.
- Miss: gnt and `ram_en_o` at t, FILL at t+1, rvalid at t+2, next gnt possible at t+2. A miss therefore costs 2 cycles.
- Reset asserted during FILL aborts the fill: no rvalid is produced and the line is left invalid.
- A request that is deasserted while gnt=0 (in FILL) is not tracked; nothing is owed to it.

## Structure
- Package `instr_line_buffer_pkg`:
  - `LINE_BYTES=16`, `WORDS_PER_LINE=4`, `OFFSET_BITS=4`.
  - State enum `ilb_state_e` {ILB_IDLE, ILB_FILL}.
- Sub-module `sat_counter32`: 32-bit saturating counter with `inc_i`, reset to 0. Instantiated twice, once for hits and once for misses.

## Test plan
- **Cold miss:** RAM line at 0x80 holds words 0x11111111, 0x22222222, 0x33333333, 0x44444444; request 0x88 at t. Required: gnt at t; `ram_en_o=1` and `ram_addr_o=0x80` at t; rvalid at t+2 with data 0x33333333; `miss_cnt_o=1`.
- **Hit stream:** after the cold miss, requests 0x80, 0x84, 0x8C on consecutive cycles. Required: three gnts, rvalids with data 0x11111111, 0x22222222, 0x44444444 on consecutive cycles, `ram_en_o` never asserted, `hit_cnt_o=3`.
- **Line change:** request 0x90 (RAM line at 0x90 starts with 0xAAAAAAAA) then 0x84. Required: both miss, with RAM addresses 0x90 then 0x80, and data 0xAAAAAAAA then 0x22222222.
- **Flush:** `flush_i` together with request 0x84 while line 0x80 is valid. Required: treated as a miss, `ram_en_o` with address 0x80, `miss_cnt_o` increments. Then `flush_i` during FILL: rvalid still arrives at t+2, and a following request to the same line misses.
- **Reset mid-fill:** miss at t, `rst_ni` low at t+1. Required: no rvalid, all outputs at their reset values; the first request after reset misses.
- **Out-of-range and unaligned address:** with `ADDR_WIDTH=22`, requests 0x0040_0081 and 0x0000_0080 map to the same line. Required: the second request hits, `instr_rdata_o`=word 0.
